piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the 6-bit serial-in shift register.
- Accepts a WIDTH-bit word on a valid/ready handshake and drives it MSB-first onto ser_out, one bit per clock.
- MSB-first order means that after WIDTH shifts the downstream register's s[WIDTH-1:0] equals the word.
- Flags that moment with a one-cycle word_done strobe. Optional start-bit framing.

Parameters:
- WIDTH, 6: data bits per word; must be >= 2.
- FRAMED, 0: when 1, a single start bit (value 1) precedes the data bits.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- clear_n  input  1  reset; asynchronous, active-low.
- load_valid  input  1  load_word is valid this cycle.
- load_word  input  WIDTH  word to serialise.
- load_ready  output  1  block will accept load_word at the next posedge.
- ser_out  output  1  serial data; feeds the downstream shift register's serial input.
- busy  output  1  a frame is in progress.
- word_done  output  1  one-cycle strobe: downstream parallel output now holds the last word.

Behaviour:
Reset (clear_n = 0, asynchronous, held any duration):
- State = IDLE; ser_out = 0; busy = 0; word_done = 0; shift register and bit counter cleared.
- load_ready = 0 while clear_n is low; it rises combinationally with clear_n.

Handshake:
- Transfer occurs at a posedge where load_valid && load_ready.
- load_word is sampled only at that edge. The source must hold load_valid and load_word until the transfer.

State machine (IDLE, START, DATA):
- IDLE: ser_out = 0, busy = 0, load_ready = 1.
  - On transfer: capture the word.
  - FRAMED = 0: go to DATA; ser_out <= word[WIDTH-1].
  - FRAMED = 1: go to START; ser_out <= 1.
- START: lasts one cycle. Next edge: go to DATA; ser_out <= word[WIDTH-1].
- DATA:
  - Counter runs WIDTH-1 down to 0. Each edge shifts the next lower bit onto ser_out.
  - load_ready = 1 only in the cycle that presents bit 0 (counter = 0); 0 in all other DATA and START cycles.
  - At the edge ending the bit-0 cycle, with a transfer: start the new frame immediately (START or DATA as above). There is no idle gap.
  - At the same edge, without a transfer: go to IDLE; ser_out <= 0.
- busy = 1 in START and DATA.

Timing:
- Latency, FRAMED = 0: word bit WIDTH-1-k is on ser_out in cycle k+1 after the transfer edge E0. The downstream register samples it at E(k+1).
- word_done:
  - Registered; high for exactly the one cycle after the edge that samples bit 0, i.e. the cycle after E(WIDTH + FRAMED).
  - It pulses even when a back-to-back frame starts on that same edge.
  - It is never high for two consecutive cycles.
- load_valid outside load_ready cycles is ignored, with no side effects.

Reset mid-frame:
- Aborts the frame and forces the reset values.
- No word_done is issued for the aborted word.
- After clear_n rises, the block is in IDLE and ready in the same cycle.

Widths:
- Counter width = clog2(WIDTH).
- No arithmetic beyond the counter decrement; the counter never wraps (it is reloaded on transfer).

Decomposition:
- Shared package: state enum (IDLE, START, DATA); constant START_BIT = 1; function for counter width.
- Single module, no sub-modules. The counter and shift register are simple enough to stay inline.

Test Plan:
1. Idle after reset: clear_n low 2 cycles then high, no load_valid -> ser_out = 0, busy = 0, load_ready = 1, word_done = 0 throughout.
2. Single word, FRAMED = 0: load 6'b101101 at E0 -> ser_out = 1,0,1,1,0,1 in cycles 1..6; word_done high only in cycle 7; downstream s = 101101 in cycle 7; busy = 0 from cycle 7.
3. Back-to-back, FRAMED = 0: 6'b101101 then 6'b010010, load_valid held high -> 12 contiguous bits 101101010010; load_ready high only in cycles 0 and 6; word_done in cycles 7 and 13.
4. Framed, FRAMED = 1: load 6'b000111 -> ser_out = 1 (start), then 0,0,0,1,1,1 in cycles 1..7; word_done in cycle 8.
5. Hold while busy: present 6'b110011 during cycle 2 of an active word -> not accepted until the bit-0 cycle; transmitted exactly once after that.
6. Reset mid-frame: assert clear_n low in cycle 3 of 6'b111111 -> ser_out = 0 immediately; no word_done ever issued; after release, a new word 6'b100001 serialises correctly.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
// The package holds the frame state encoding, the start-bit value and the counter sizing helper.
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic START_BIT = 1'b1;

    // The counter must hold WIDTH-1; a one-bit minimum keeps tiny widths legal.
    function automatic int cnt_width(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Serialises WIDTH-bit words MSB-first onto ser_out, with an optional leading start bit.
// Frames may follow each other with no gap when the next word is offered in the bit-0 cycle.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter bit FRAMED = 1'b0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_word,
    output logic             load_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             ser_nx;
    logic             done_nx;
    logic             take;
    logic             last_bit;

    assign last_bit   = (state == DATA) && (cnt == '0);
    assign load_ready = clear_n && ((state == IDLE) || last_bit);
    assign take       = load_valid && load_ready;
    assign busy       = (state != IDLE);

    // A transfer overrides the per-state behaviour, which is what makes back-to-back frames seamless.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        ser_nx   = ser_out;
        done_nx  = last_bit;
        if (take) begin
            cnt_nx = CNT_MAX;
            if (FRAMED) begin
                state_nx = START;
                ser_nx   = START_BIT;
                shreg_nx = load_word;
            end else begin
                state_nx = DATA;
                ser_nx   = load_word[WIDTH-1];
                shreg_nx = {load_word[WIDTH-2:0], 1'b0};
            end
        end else begin
            case (state)
                IDLE: begin
                    ser_nx = 1'b0;
                end
                START: begin
                    state_nx = DATA;
                    cnt_nx   = CNT_MAX;
                    ser_nx   = shreg[WIDTH-1];
                    shreg_nx = {shreg[WIDTH-2:0], 1'b0};
                end
                DATA: begin
                    if (cnt == '0) begin
                        state_nx = IDLE;
                        ser_nx   = 1'b0;
                    end else begin
                        cnt_nx   = cnt - 1'b1;
                        ser_nx   = shreg[WIDTH-1];
                        shreg_nx = {shreg[WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    state_nx = IDLE;
                    ser_nx   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            ser_out   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            shreg     <= shreg_nx;
            ser_out   <= ser_nx;
            word_done <= done_nx;
        end
    end

endmodule
